// File: rtl/counter_pkg.sv
// Shared counter definitions: direction encodings and a constant-width helper
// for sizing prescaler registers.
package counter_pkg;

  localparam logic CNT_DIR_UP   = 1'b1;
  localparam logic CNT_DIR_DOWN = 1'b0;

  // Bits needed to hold 0..v-1, never less than one.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < v) r = 32'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler: emits a tick on every PRESCALE-th enabled cycle.
// With PRESCALE = 1 the tick is the enable itself and no register exists.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o
);

  if (PRESCALE <= 1) begin : g_bypass
    logic unused_c;
    assign unused_c = clk ^ reset ^ clear_i;
    assign tick_o   = enable_i;
  end else begin : g_div
    localparam int unsigned PW = clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q, pre_d;

    assign tick_o = enable_i && (pre_q == LAST);

    always_comb begin
      pre_d = pre_q;
      if (clear_i) begin
        pre_d = '0;
      end else if (enable_i) begin
        pre_d = (pre_q == LAST) ? '0 : pre_q + PW'(1);
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) pre_q <= '0;
      else        pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/modn_updown_counter.sv
// Modulo-N up/down counter with load, clear, wrap/saturate boundary mode,
// enable prescaler and terminal-count / sticky overflow status.
module modn_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MOD_MAX  = 32'((64'd1 << WIDTH) - 64'd1),
  parameter bit          SATURATE = 1'b0,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             enable,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             at_max,
  output logic             at_zero,
  output logic             ovf_sticky
);

  if (WIDTH < 2) begin : g_bad_width
    $error("modn_updown_counter: WIDTH must be >= 2");
  end
  if (MOD_MAX < 1 || 64'(MOD_MAX) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_mod
    $error("modn_updown_counter: MOD_MAX must lie in 1..2**WIDTH-1");
  end
  if (PRESCALE < 1) begin : g_bad_pre
    $error("modn_updown_counter: PRESCALE must be >= 1");
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD_MAX);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             tick;

  // Clear and load both restart the prescaler.
  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (clear | load),
    .enable_i (enable),
    .tick_o   (tick)
  );

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = (data_in > MAX_V) ? MAX_V : data_in;
      ovf_d   = 1'b0;
    end else if (tick) begin
      if (up == CNT_DIR_UP) begin
        if (count_q == MAX_V) begin
          count_d = SATURATE ? MAX_V : '0;
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d = SATURATE ? '0 : MAX_V;
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count      = count_q;
  assign tc         = tc_q;
  assign ovf_sticky = ovf_q;
  assign at_max     = (count_q == MAX_V);
  assign at_zero    = (count_q == '0);

endmodule

// File: tb/tb_modn_updown_counter.sv
// Bench for modn_updown_counter: wrap, saturate and prescaled instances share
// stimulus and are each compared against an arithmetic reference model.
module tb_modn_updown_counter;

  localparam int W  = 4;
  localparam int MM = 9;
  localparam int NI = 3;

  typedef struct {
    int cnt;
    int pre;
    bit tc;
    bit ovf;
  } mst_t;

  typedef struct {
    bit clr; bit ld; int d; bit en; bit up;
    int wc; bit wt; bit wo;
    int sc; bit st; bit so;
  } vec_t;

  int ps_of[NI]  = '{1, 1, 3};
  bit sat_of[NI] = '{1'b0, 1'b1, 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, clear, load, enable, up;
  logic [W-1:0] data_in;
  logic [W-1:0] cnt_o[NI];
  logic tc_o[NI], max_o[NI], zero_o[NI], ovf_o[NI];

  modn_updown_counter #(.WIDTH(W), .MOD_MAX(MM), .SATURATE(1'b0), .PRESCALE(1)) u_wrap (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .data_in(data_in),
    .enable(enable), .up(up), .count(cnt_o[0]), .tc(tc_o[0]), .at_max(max_o[0]),
    .at_zero(zero_o[0]), .ovf_sticky(ovf_o[0]));

  modn_updown_counter #(.WIDTH(W), .MOD_MAX(MM), .SATURATE(1'b1), .PRESCALE(1)) u_sat (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .data_in(data_in),
    .enable(enable), .up(up), .count(cnt_o[1]), .tc(tc_o[1]), .at_max(max_o[1]),
    .at_zero(zero_o[1]), .ovf_sticky(ovf_o[1]));

  modn_updown_counter #(.WIDTH(W), .MOD_MAX(MM), .SATURATE(1'b0), .PRESCALE(3)) u_pre (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .data_in(data_in),
    .enable(enable), .up(up), .count(cnt_o[2]), .tc(tc_o[2]), .at_max(max_o[2]),
    .at_zero(zero_o[2]), .ovf_sticky(ovf_o[2]));

  mst_t m[NI];
  vec_t tbl[$];
  int n_cmp = 0;
  int n_fail = 0;

  // Reference step: the count moves by +/-1; anything outside 0..MM is a boundary event.
  function automatic mst_t mstep(mst_t s, int ix, bit c, bit l, int d, bit e, bit u);
    mst_t n;
    int raw;
    n = s;
    n.tc = 1'b0;
    if (c) begin
      n = '{0, 0, 1'b0, 1'b0};
    end else if (l) begin
      n.cnt = (d > MM) ? MM : d;
      n.pre = 0;
      n.ovf = 1'b0;
    end else if (e) begin
      n.pre = (s.pre + 1) % ps_of[ix];
      if (n.pre == 0) begin
        raw = u ? s.cnt + 1 : s.cnt - 1;
        if (raw < 0 || raw > MM) begin
          n.tc  = 1'b1;
          n.ovf = 1'b1;
          n.cnt = sat_of[ix] ? s.cnt : (raw + MM + 1) % (MM + 1);
        end else begin
          n.cnt = raw;
        end
      end
    end
    return n;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s[%0d].count", tag, i), int'(cnt_o[i]), m[i].cnt);
      check($sformatf("%s[%0d].tc", tag, i), int'(tc_o[i]), int'(m[i].tc));
      check($sformatf("%s[%0d].ovf", tag, i), int'(ovf_o[i]), int'(m[i].ovf));
      check($sformatf("%s[%0d].at_max", tag, i), int'(max_o[i]), int'(m[i].cnt == MM));
      check($sformatf("%s[%0d].at_zero", tag, i), int'(zero_o[i]), int'(m[i].cnt == 0));
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) m[i] = '{0, 0, 1'b0, 1'b0};
  endtask

  task automatic cycle(input string tag, input bit c, input bit l, input int d,
                       input bit e, input bit u);
    clear = c; load = l; data_in = W'(d); enable = e; up = u;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < NI; i++) m[i] = mstep(m[i], i, c, l, d, e, u);
    end else begin
      model_reset();
    end
    #1;
    check_all(tag);
  endtask

  // Reset asserted between clock edges must clear everything at once.
  task automatic async_pulse();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #2;
    reset = 1'b1;
  endtask

  task automatic addv(input bit c, input bit l, input int d, input bit e, input bit u,
                      input int wc, input bit wt, input bit wo,
                      input int sc, input bit st, input bit so);
    vec_t v;
    v = '{c, l, d, e, u, wc, wt, wo, sc, st, so};
    tbl.push_back(v);
  endtask

  bit en_pat[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  int exp_pre[7] = '{0, 0, 0, 1, 1, 1, 2};

  initial begin
    bit rc, rl, re, ru;
    int rd;

    addv(1, 0, 0, 0, 1,  0, 0, 0,  0, 0, 0);
    for (int k = 1; k <= 9; k++) addv(0, 0, 0, 1, 1,  k, 0, 0,  k, 0, 0);
    addv(0, 0, 0, 1, 1,  0, 1, 1,  9, 1, 1);
    addv(0, 0, 0, 1, 1,  1, 0, 1,  9, 1, 1);
    addv(0, 1, 13, 1, 1, 9, 0, 0,  9, 0, 0);
    addv(0, 0, 0, 1, 0,  8, 0, 0,  8, 0, 0);
    addv(0, 0, 0, 1, 1,  9, 0, 0,  9, 0, 0);
    addv(0, 0, 0, 1, 1,  0, 1, 1,  9, 1, 1);
    addv(0, 1, 2, 0, 1,  2, 0, 0,  2, 0, 0);
    addv(0, 0, 0, 1, 0,  1, 0, 0,  1, 0, 0);
    addv(0, 0, 0, 1, 0,  0, 0, 0,  0, 0, 0);
    addv(0, 0, 0, 1, 0,  9, 1, 1,  0, 1, 1);
    addv(0, 0, 0, 1, 0,  8, 0, 1,  0, 1, 1);
    addv(1, 1, 5, 1, 1,  0, 0, 0,  0, 0, 0);
    addv(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0);

    reset = 1'b0; clear = 1'b0; load = 1'b0; enable = 1'b0; up = 1'b1; data_in = '0;
    model_reset();
    #1;
    check_all("reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    foreach (tbl[k]) begin
      cycle("tbl", tbl[k].clr, tbl[k].ld, tbl[k].d, tbl[k].en, tbl[k].up);
      check($sformatf("tbl%0d.wrap.count", k), int'(cnt_o[0]), tbl[k].wc);
      check($sformatf("tbl%0d.wrap.tc", k), int'(tc_o[0]), int'(tbl[k].wt));
      check($sformatf("tbl%0d.wrap.ovf", k), int'(ovf_o[0]), int'(tbl[k].wo));
      check($sformatf("tbl%0d.sat.count", k), int'(cnt_o[1]), tbl[k].sc);
      check($sformatf("tbl%0d.sat.tc", k), int'(tc_o[1]), int'(tbl[k].st));
      check($sformatf("tbl%0d.sat.ovf", k), int'(ovf_o[1]), int'(tbl[k].so));
    end

    cycle("pre_clr", 1, 0, 0, 0, 1);
    for (int k = 0; k < 7; k++) begin
      cycle("pre", 0, 0, 0, en_pat[k], 1);
      check($sformatf("pre_seq%0d.count", k), int'(cnt_o[2]), exp_pre[k]);
    end

    cycle("rst_clr", 1, 0, 0, 0, 1);
    repeat (15) cycle("rst_run", 0, 0, 0, 1, 1);
    check("rst_pre.count", int'(cnt_o[0]), 5);
    check("rst_pre.ovf", int'(ovf_o[0]), 1);
    async_pulse();
    check("rst_now.count", int'(cnt_o[0]), 0);
    check("rst_now.ovf", int'(ovf_o[0]), 0);
    cycle("rst_resume", 0, 0, 0, 1, 1);
    check("rst_resume.count", int'(cnt_o[0]), 1);
    repeat (3) cycle("clr_run", 0, 0, 0, 1, 1);
    cycle("clr", 1, 0, 0, 1, 1);
    check("clr.count", int'(cnt_o[0]), 0);

    ru = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      rc = ($urandom_range(0, 39) == 0);
      rl = ($urandom_range(0, 29) == 0);
      rd = int'($urandom_range(0, 15));
      re = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) ru = ~ru;
      cycle("rand", rc, rl, rd, re, ru);
      if ($urandom_range(0, 299) == 0) async_pulse();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/modn_updown_counter.md
# modn_updown_counter

Parametrised modulo-N up/down counter, the successor to the team's fixed 8-bit load/enable counter. It adds generic width, a programmable terminal value, direction control, a wrap or saturate mode, an enable prescaler, and terminal-count/overflow status. It sits in timer, PWM and event-counting paths, where a single counter core replaces per-width copies.

## Interface
- WIDTH, 8, count width in bits; must be ≥ 2.
- MOD_MAX, 2**WIDTH-1, upper bound of the count range, so the count runs 0..MOD_MAX; must satisfy 1 ≤ MOD_MAX ≤ 2**WIDTH-1.
- SATURATE, 0, boundary mode: 0 = wrap around, 1 = hold at the boundary.
- PRESCALE, 1, number of enabled cycles per count step; must be ≥ 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset.
- clear  in  1  synchronous clear of count, prescaler and ovf_sticky.
- load  in  1  synchronous load of data_in.
- data_in  in  WIDTH  load value.
- enable  in  1  count-enable qualifier.
- up  in  1  direction: 1 = increment, 0 = decrement.
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal-count pulse, registered, one cycle wide.
- at_max  out  1  count == MOD_MAX, decoded from the count register.
- at_zero  out  1  count == 0, decoded from the count register.
- ovf_sticky  out  1  latched boundary event, registered.

## Operation
- Priority, highest first: reset, clear, load, step.
- reset low forces count = 0, prescaler = 0, tc = 0 and ovf_sticky = 0 immediately; this is independent of clk.
- clear: same effect as reset, but taken at the next clk edge.
- load:
  - count <= data_in if data_in ≤ MOD_MAX; otherwise count <= MOD_MAX (clamped).
  - Prescaler returns to 0; ovf_sticky clears; tc = 0.
- Prescaler:
  - pre_cnt advances only in cycles where enable = 1 and neither clear nor load is active.
  - Tick when enable = 1 and pre_cnt == PRESCALE-1; pre_cnt then returns to 0.
  - pre_cnt holds its value while enable = 0.
  - With PRESCALE = 1, tick = enable, and no prescaler register is built.
- Step (on a tick):
  - up = 1, count < MOD_MAX: count+1.
  - up = 1, count == MOD_MAX: next count is 0 (SATURATE = 0) or MOD_MAX held (SATURATE = 1); this is a boundary event.
  - up = 0, count > 0: count-1.
  - up = 0, count == 0: next count is MOD_MAX (SATURATE = 0) or 0 held (SATURATE = 1); this is a boundary event.
- Boundary handling occurs only on a step. A count sitting at a boundary with no tick never wraps, and a load of MOD_MAX is not an event.
- On a boundary event, tc = 1 for exactly one cycle and ovf_sticky is set. ovf_sticky stays set until reset, clear or load.
- A direction change takes effect on the next tick and does not reset the prescaler.
- Arithmetic is WIDTH bits and never relies on natural 2**WIDTH rollover, so it stays correct for non-power-of-two MOD_MAX.

## Timing
- Single clk domain; every output except at_max and at_zero is a flop.
- Latency: a tick sampled at edge N updates count at edge N.
  - tc is high during the cycle after edge N, alongside the new count.
  - ovf_sticky is high from edge N onward.
- Back-to-back ticks (PRESCALE = 1, enable held) step every cycle, so tc can assert on consecutive boundary events with SATURATE = 1.
- clear or load on the same edge as a tick: the tick is discarded and tc = 0.
- Reset deasserting mid-operation: counting resumes from 0 at the first clk edge where reset = 1, with the prescaler restarting at 0.

## Structure
- Shared package counter_pkg holds:
  - CNT_DIR_UP = 1'b1 and CNT_DIR_DOWN = 1'b0;
  - a clog2 function used to size pre_cnt as clog2(PRESCALE), minimum 1 bit.
- Sub-module counter_prescaler(PRESCALE) takes clk, reset, clear_i, enable_i and outputs tick_o; it is reusable by the team's timer blocks.
- Parameter legality (MOD_MAX range, PRESCALE ≥ 1) is checked by an elaboration-time assertion in the top module.

## Test plan
- Reset and clear: reset = 0 mid-count at count = 5 -> count = 0, tc = 0, ovf_sticky = 0 with no clk edge; clear = 1 one cycle later gives the same result on the edge.
- Wrap up, WIDTH = 4, MOD_MAX = 9, SATURATE = 0, PRESCALE = 1: enable = 1, up = 1 from 0 -> count goes 0..9, then 0; tc is high for one cycle alongside count = 0; ovf_sticky = 1.
- Saturate down, MOD_MAX = 9, SATURATE = 1: load 2, then up = 0 for 4 ticks -> count goes 1, 0, 0, 0; tc is high on the two held-at-0 steps.
- Load clamp and priority, MOD_MAX = 9: load = 1 with data_in = 13 while a tick is present -> count = 9, tc = 0, ovf_sticky cleared; with load and clear both high -> count = 0.
- Prescaler, PRESCALE = 3: enable pattern 1,1,0,1,1,1,1 -> count increments only after the 3rd and 6th enabled cycles, i.e. on the 4th and 7th clk cycles of the pattern.
- Direction flip at a boundary, MOD_MAX = 9, SATURATE = 0: count = 9, tick with up = 0 -> 8; next tick with up = 1 -> 9; next tick with up = 1 -> 0 with tc = 1.
